strength_charge_net: RTL and testbench
======================================

Name: strength_charge_net

Overview:
- Cycle-based model of a multi-channel resolved net with Verilog-style drive strengths and trireg charge retention.
- Each channel resolves up to NUM_DRV strength-tagged drivers per cycle.
- When every driver releases, the channel holds its last value at a selectable charge strength, then decays to X after a programmable number of cycles.
- Used by the semantic-facts harnesses as a synthesizable reference for strength and charge behaviour.

Parameters:
- NUM_CH, 2, number of independent nets.
- NUM_DRV, 4, drivers per net.
- DECAY_SMALL, 4, retention cycles for small charge; 0 = infinite retention.
- DECAY_MEDIUM, 16, retention cycles for medium charge; 0 = infinite.
- DECAY_LARGE, 64, retention cycles for large charge; 0 = infinite.
- CNT_W, 8, width of decay counter; must hold the largest DECAY_*.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- drv_en  in  NUM_CH*NUM_DRV  driver enable; bit index = ch*NUM_DRV+d.
- drv_val  in  NUM_CH*NUM_DRV  driven logic value.
- drv_str0  in  NUM_CH*NUM_DRV*3  strength used when driving 0.
- drv_str1  in  NUM_CH*NUM_DRV*3  strength used when driving 1.
- charge_str  in  NUM_CH*2  charge size: 00 small, 01 medium, 10 large, 11 medium.
- net_val  out  NUM_CH*2  value code: 00=0, 01=1, 10=X, 11=Z.
- net_str  out  NUM_CH*3  resolved strength.
- decay_evt  out  NUM_CH  one-cycle pulse when a channel's charge decays to X.
- any_conflict  out  1  OR over channels resolved X by equal-strength conflict this cycle.

Behaviour:
- Strength codes: 7 supply, 6 strong, 5 pull, 4 large, 3 weak, 2 medium, 1 small, 0 highz. Charge strengths: small=1, medium=2, large=4.
- Reset (async, rst_n=0):
  - every channel enters UNCHARGED;
  - net_val=Z(11), net_str=0, decay_evt=0, any_conflict=0;
  - counters cleared;
  - release takes effect on the next posedge.
- Latency: inputs sampled at posedge; all outputs registered, valid 1 cycle later.
- Driver contribution:
  - enabled driver strength s = drv_val ? str1 : str0;
  - s==0 (highz) contributes nothing;
  - disabled drivers contribute nothing.
- Resolution, when at least one contributor exists:
  - max = highest contributing strength;
  - all max-strength contributors agree -> that value; otherwise X with conflict flag;
  - lower strengths are ignored; net_str=max; state DRIVEN;
  - any driver with s>0 overrides stored charge regardless of charge strength.
- States per channel:
  - UNCHARGED: no contributors -> stay, Z, str 0. Contributor -> DRIVEN.
  - DRIVEN: no contributors and last value 0/1 -> CHARGED, hold last value, str = charge strength, counter = DECAY_* for current charge_str. Last value X -> DECAYED directly, no decay_evt.
  - CHARGED: contributor -> DRIVEN. Otherwise, if DECAY_* (at load) is nonzero, counter decrements; when counter was 1 -> DECAYED, value X, decay_evt=1 for exactly one cycle. DECAY_*=0 holds forever.
  - DECAYED: value X, str = charge strength; contributor -> DRIVEN.
- charge_str change while CHARGED/DECAYED: net_str follows the new value next cycle; the counter is not reloaded.
- Counter expiry and a returning driver in the same cycle: driver wins, DRIVEN, no decay_evt.
- Release with all drivers highz is identical to all drivers disabled.
- Channels are fully independent; any_conflict is registered with net_val.

Test Plan:
- Reset -> all net_val=11, net_str=0, decay_evt=0. Assert rst_n=0 while CHARGED -> outputs return to Z/0 immediately, without a clock edge.
- ch0: d0 drives 1 at strong1 (6), d1 drives 0 at weak0 (3) -> net_val=01, net_str=6, any_conflict=0. Then d0 and d1 both at pull (5) with opposite values -> net_val=10, net_str=5, any_conflict=1.
- ch0 driven 1 strong, charge_str=00, DECAY_SMALL=4, then all released -> net_val=01, net_str=1 for 4 cycles. Then net_val=10 with decay_evt high for 1 cycle. ch1 unaffected throughout.
- Release with charge_str=10, then redrive 0 at pull in the expiry cycle -> net_val=00, net_str=5, decay_evt never asserted.
- Only driver enabled as highz0 driving 0 after a prior strong 1 -> treated as release: net_val=01, net_str=charge strength, decay counting starts.
- Change charge_str from 00 to 10 mid-retention -> net_str goes 1->4 next cycle; decay still fires at the original count.

Source files
------------

// File: rtl/strength_charge_net.sv
// Multi-channel resolved net with drive strengths and trireg-style charge retention.
module strength_charge_net #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned NUM_DRV      = 4,
    parameter int unsigned DECAY_SMALL  = 4,
    parameter int unsigned DECAY_MEDIUM = 16,
    parameter int unsigned DECAY_LARGE  = 64,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH*NUM_DRV-1:0]   drv_en,
    input  logic [NUM_CH*NUM_DRV-1:0]   drv_val,
    input  logic [NUM_CH*NUM_DRV*3-1:0] drv_str0,
    input  logic [NUM_CH*NUM_DRV*3-1:0] drv_str1,
    input  logic [NUM_CH*2-1:0]         charge_str,
    output logic [NUM_CH*2-1:0]         net_val,
    output logic [NUM_CH*3-1:0]         net_str,
    output logic [NUM_CH-1:0]           decay_evt,
    output logic                        any_conflict
);

    localparam logic [1:0] VAL_0 = 2'b00;
    localparam logic [1:0] VAL_1 = 2'b01;
    localparam logic [1:0] VAL_X = 2'b10;
    localparam logic [1:0] VAL_Z = 2'b11;

    typedef enum logic [1:0] {
        S_UNCHARGED = 2'd0,
        S_DRIVEN    = 2'd1,
        S_CHARGED   = 2'd2,
        S_DECAYED   = 2'd3
    } state_t;

    state_t           state_q [NUM_CH];
    state_t           state_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q   [NUM_CH];
    logic [CNT_W-1:0] cnt_d   [NUM_CH];

    logic [2:0]          res_str [NUM_CH];
    logic [NUM_CH-1:0]   res_h0;
    logic [NUM_CH-1:0]   res_h1;

    logic [NUM_CH*2-1:0] val_d;
    logic [NUM_CH*3-1:0] str_d;
    logic [NUM_CH-1:0]   evt_d;
    logic [NUM_CH-1:0]   conf_d;

    // Strength a stored charge presents, by charge size select.
    function automatic logic [2:0] charge_level(input logic [1:0] sel);
        case (sel)
            2'b00:   return 3'd1;
            2'b10:   return 3'd4;
            default: return 3'd2;
        endcase
    endfunction

    // Retention length loaded when charge is captured; zero means hold forever.
    function automatic logic [CNT_W-1:0] decay_load(input logic [1:0] sel);
        case (sel)
            2'b00:   return CNT_W'(DECAY_SMALL);
            2'b10:   return CNT_W'(DECAY_LARGE);
            default: return CNT_W'(DECAY_MEDIUM);
        endcase
    endfunction

    // Per channel: strongest contributing strength and which values appear at it.
    always_comb begin
        logic [2:0] s;
        int unsigned idx;
        s      = 3'd0;
        idx    = 0;
        res_h0 = '0;
        res_h1 = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            res_str[c] = 3'd0;
            for (int d = 0; d < NUM_DRV; d++) begin
                idx = c * NUM_DRV + d;
                s   = drv_val[idx] ? drv_str1[idx*3 +: 3] : drv_str0[idx*3 +: 3];
                if (drv_en[idx] && (s != 3'd0)) begin
                    if (s > res_str[c]) begin
                        res_str[c] = s;
                        res_h0[c]  = ~drv_val[idx];
                        res_h1[c]  = drv_val[idx];
                    end else if (s == res_str[c]) begin
                        res_h0[c]  = res_h0[c] | ~drv_val[idx];
                        res_h1[c]  = res_h1[c] | drv_val[idx];
                    end
                end
            end
        end
    end

    // Next state, retention counter and next registered outputs per channel.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = net_val;
        str_d   = net_str;
        evt_d   = '0;
        conf_d  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (res_str[c] != 3'd0) begin
                state_d[c]       = S_DRIVEN;
                str_d[c*3 +: 3]  = res_str[c];
                if (res_h0[c] && res_h1[c]) begin
                    val_d[c*2 +: 2] = VAL_X;
                    conf_d[c]       = 1'b1;
                end else begin
                    val_d[c*2 +: 2] = res_h1[c] ? VAL_1 : VAL_0;
                end
            end else begin
                str_d[c*3 +: 3] = charge_level(charge_str[c*2 +: 2]);
                case (state_q[c])
                    S_UNCHARGED: begin
                        val_d[c*2 +: 2] = VAL_Z;
                        str_d[c*3 +: 3] = 3'd0;
                    end
                    S_DRIVEN: begin
                        // A conflicted (X) net has no charge worth keeping.
                        if (net_val[c*2 +: 2] == VAL_X) begin
                            state_d[c] = S_DECAYED;
                        end else begin
                            state_d[c] = S_CHARGED;
                            cnt_d[c]   = decay_load(charge_str[c*2 +: 2]);
                        end
                    end
                    S_CHARGED: begin
                        if (cnt_q[c] != '0) begin
                            if (cnt_q[c] == CNT_W'(1)) begin
                                state_d[c]      = S_DECAYED;
                                cnt_d[c]        = '0;
                                val_d[c*2 +: 2] = VAL_X;
                                evt_d[c]        = 1'b1;
                            end else begin
                                cnt_d[c] = cnt_q[c] - CNT_W'(1);
                            end
                        end
                    end
                    S_DECAYED: begin
                        val_d[c*2 +: 2] = VAL_X;
                    end
                endcase
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= S_UNCHARGED;
                cnt_q[c]   <= '0;
            end
            net_val      <= {NUM_CH{VAL_Z}};
            net_str      <= '0;
            decay_evt    <= '0;
            any_conflict <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            net_val      <= val_d;
            net_str      <= str_d;
            decay_evt    <= evt_d;
            any_conflict <= |conf_d;
        end
    end

endmodule

// File: tb/tb_strength_charge_net.sv
// Self-checking bench: behavioural history model plus directed literal checks.
module tb_strength_charge_net;

    localparam int NUM_CH       = 2;
    localparam int NUM_DRV      = 4;
    localparam int DECAY_SMALL  = 4;
    localparam int DECAY_MEDIUM = 16;
    localparam int DECAY_LARGE  = 64;
    localparam int CNT_W        = 8;
    localparam int NB           = NUM_CH * NUM_DRV;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NB-1:0]       drv_en;
    logic [NB-1:0]       drv_val;
    logic [NB*3-1:0]     drv_str0;
    logic [NB*3-1:0]     drv_str1;
    logic [NUM_CH*2-1:0] charge_str;
    logic [NUM_CH*2-1:0] net_val;
    logic [NUM_CH*3-1:0] net_str;
    logic [NUM_CH-1:0]   decay_evt;
    logic                any_conflict;

    int errors = 0;
    int checks = 0;
    int evt0_count = 0;

    // Model: history of each net (ever driven, last driven value, cycles since release).
    bit ever   [NUM_CH];
    int last_v [NUM_CH];
    int age    [NUM_CH];
    int dload  [NUM_CH];
    int e_val  [NUM_CH];
    int e_str  [NUM_CH];
    int e_evt  [NUM_CH];
    int e_conf [NUM_CH];
    int e_any;

    strength_charge_net #(
        .NUM_CH(NUM_CH), .NUM_DRV(NUM_DRV), .DECAY_SMALL(DECAY_SMALL),
        .DECAY_MEDIUM(DECAY_MEDIUM), .DECAY_LARGE(DECAY_LARGE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_val(drv_val),
        .drv_str0(drv_str0), .drv_str1(drv_str1), .charge_str(charge_str),
        .net_val(net_val), .net_str(net_str), .decay_evt(decay_evt),
        .any_conflict(any_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int charge_strength(input int sel);
        if (sel == 0) return 1;
        if (sel == 2) return 4;
        return 2;
    endfunction

    function automatic int decay_cycles(input int sel);
        if (sel == 0) return DECAY_SMALL;
        if (sel == 2) return DECAY_LARGE;
        return DECAY_MEDIUM;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            ever[c] = 1'b0; last_v[c] = 3; age[c] = 0; dload[c] = 0;
            e_val[c] = 3; e_str[c] = 0; e_evt[c] = 0; e_conf[c] = 0;
        end
        e_any = 0;
    endtask

    task automatic model_step();
        int mx, s, idx, cs;
        bit h0, h1;
        e_any = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            mx = 0; h0 = 1'b0; h1 = 1'b0;
            for (int d = 0; d < NUM_DRV; d++) begin
                idx = c * NUM_DRV + d;
                s = drv_val[idx] ? int'(drv_str1[idx*3 +: 3]) : int'(drv_str0[idx*3 +: 3]);
                if (drv_en[idx] && s > 0) begin
                    if (s > mx) begin
                        mx = s; h0 = !drv_val[idx]; h1 = drv_val[idx];
                    end else if (s == mx) begin
                        h0 = h0 | !drv_val[idx]; h1 = h1 | drv_val[idx];
                    end
                end
            end
            cs = int'(charge_str[c*2 +: 2]);
            e_evt[c] = 0; e_conf[c] = 0;
            if (mx > 0) begin
                ever[c]   = 1'b1;
                last_v[c] = (h0 && h1) ? 2 : (h1 ? 1 : 0);
                age[c]    = 0;
                e_val[c]  = last_v[c];
                e_str[c]  = mx;
                e_conf[c] = (h0 && h1) ? 1 : 0;
            end else if (!ever[c]) begin
                e_val[c] = 3; e_str[c] = 0;
            end else begin
                if (age[c] == 0) dload[c] = decay_cycles(cs);
                if (age[c] < 1000000) age[c]++;
                e_str[c] = charge_strength(cs);
                if (last_v[c] == 2) e_val[c] = 2;
                else if (dload[c] == 0 || age[c] <= dload[c]) e_val[c] = last_v[c];
                else begin
                    e_val[c] = 2;
                    e_evt[c] = (age[c] == dload[c] + 1) ? 1 : 0;
                end
            end
            if (e_conf[c] != 0) e_any = 1;
        end
    endtask

    // Advance the model on each sampling edge and compare all outputs just after it.
    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step();
            #1;
            for (int c = 0; c < NUM_CH; c++) begin
                chk($sformatf("net_val ch%0d", c), int'(net_val[c*2 +: 2]), e_val[c]);
                chk($sformatf("net_str ch%0d", c), int'(net_str[c*3 +: 3]), e_str[c]);
                chk($sformatf("decay_evt ch%0d", c), int'(decay_evt[c]), e_evt[c]);
            end
            chk("any_conflict", int'(any_conflict), e_any);
            if (decay_evt[0]) evt0_count++;
        end
    end

    task automatic set_drv(input int c, input int d, input bit en, input bit v,
                           input int s0, input int s1);
        int idx;
        idx = c * NUM_DRV + d;
        drv_en[idx]          = en;
        drv_val[idx]         = v;
        drv_str0[idx*3 +: 3] = 3'(s0);
        drv_str1[idx*3 +: 3] = 3'(s1);
    endtask

    task automatic release_ch(input int c);
        for (int d = 0; d < NUM_DRV; d++) set_drv(c, d, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_charge(input int c, input int sel);
        charge_str[c*2 +: 2] = 2'(sel);
    endtask

    task automatic chk_ch(input string tag, input int c, input int v, input int s, input int e);
        chk({tag, " val"}, int'(net_val[c*2 +: 2]), v);
        chk({tag, " str"}, int'(net_str[c*3 +: 3]), s);
        chk({tag, " evt"}, int'(decay_evt[c]), e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int quiet [NUM_CH];
    int ev_before;

    initial begin
        rst_n = 1'b0;
        drv_en = '0; drv_val = '0; drv_str0 = '0; drv_str1 = '0; charge_str = '0;
        model_reset();
        step(3);
        for (int c = 0; c < NUM_CH; c++) chk_ch("reset", c, 3, 0, 0);
        chk("reset conflict", int'(any_conflict), 0);
        rst_n = 1'b1;

        // Strong 1 beats weak 0; then equal pull strengths conflict.
        set_drv(0, 0, 1'b1, 1'b1, 0, 6);
        set_drv(0, 1, 1'b1, 1'b0, 3, 0);
        step(1);
        chk_ch("strong_wins", 0, 1, 6, 0);
        chk("strong_wins conflict", int'(any_conflict), 0);
        set_drv(0, 0, 1'b1, 1'b1, 0, 5);
        set_drv(0, 1, 1'b1, 1'b0, 5, 0);
        step(1);
        chk_ch("pull_conflict", 0, 2, 5, 0);
        chk("pull_conflict flag", int'(any_conflict), 1);

        // Small charge retained four cycles then decays; ch1 held at strong 0.
        set_drv(1, 0, 1'b1, 1'b0, 6, 0);
        set_charge(0, 0);
        release_ch(0);
        set_drv(0, 0, 1'b1, 1'b1, 0, 6);
        step(1);
        release_ch(0);
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk_ch("small_hold", 0, 1, 1, 0);
            chk_ch("ch1_steady", 1, 0, 6, 0);
        end
        step(1);
        chk_ch("small_decay", 0, 2, 1, 1);
        step(1);
        chk_ch("after_decay", 0, 2, 1, 0);

        // Large charge: redrive lands exactly on the expiry edge.
        set_charge(0, 2);
        set_drv(0, 0, 1'b1, 1'b1, 0, 6);
        step(1);
        ev_before = evt0_count;
        release_ch(0);
        step(64);
        chk_ch("large_hold_end", 0, 1, 4, 0);
        set_drv(0, 0, 1'b1, 1'b0, 5, 0);
        step(1);
        chk_ch("redrive_at_expiry", 0, 0, 5, 0);
        step(1);
        chk("no_decay_evt_in_window", evt0_count - ev_before, 0);

        // Lone highz0 driver equals a release.
        set_charge(0, 1);
        set_drv(0, 0, 1'b1, 1'b1, 0, 6);
        step(1);
        set_drv(0, 0, 1'b1, 1'b0, 0, 6);
        step(1);
        chk_ch("highz_release", 0, 1, 2, 0);
        step(15);
        chk_ch("medium_hold_end", 0, 1, 2, 0);
        step(1);
        chk_ch("medium_decay", 0, 2, 2, 1);

        // Charge size change mid-retention: strength follows, count does not reload.
        set_charge(0, 0);
        set_drv(0, 0, 1'b1, 1'b1, 0, 6);
        step(1);
        release_ch(0);
        step(2);
        chk_ch("resize_before", 0, 1, 1, 0);
        set_charge(0, 2);
        step(1);
        chk_ch("resize_str", 0, 1, 4, 0);
        step(1);
        chk_ch("resize_hold", 0, 1, 4, 0);
        step(1);
        chk_ch("resize_decay", 0, 2, 4, 1);

        // Async reset while charged clears outputs without a clock edge.
        set_drv(0, 0, 1'b1, 1'b1, 0, 6);
        step(1);
        release_ch(0);
        step(2);
        #2 rst_n = 1'b0;
        #1;
        for (int c = 0; c < NUM_CH; c++) chk_ch("async_reset", c, 3, 0, 0);
        chk("async_reset conflict", int'(any_conflict), 0);
        step(2);
        drv_en = '0;
        rst_n = 1'b1;

        // Randomized traffic with quiet periods to exercise retention and decay.
        for (int c = 0; c < NUM_CH; c++) quiet[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 31) == 0) set_charge(c, int'($urandom_range(0, 3)));
                if (quiet[c] > 0) begin
                    quiet[c]--;
                    for (int d = 0; d < NUM_DRV; d++)
                        set_drv(c, d, 1'($urandom), 1'($urandom), 0, 0);
                end else begin
                    if ($urandom_range(0, 15) == 0) quiet[c] = int'($urandom_range(0, 80));
                    for (int d = 0; d < NUM_DRV; d++)
                        set_drv(c, d, 1'($urandom), 1'($urandom),
                                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
                end
            end
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
